// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU control FSM and mem_responder.
interface mem_responder_if #(
    parameter int N = 32
);
    logic         MemRead;
    logic         MemWrite;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         ready;
    logic         busy;
    logic         err;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word memory with programmable wait states and a one-cycle ready pulse.
// MEM_ERR_CHECK_EN enables alignment/range error reporting on err.
module mem_responder #(
    parameter int N           = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [N-1:0]  wbuf, wbuf_nx;
    logic          op_wr, op_wr_nx;
    logic          bad, bad_nx;
    logic          ready_q, busy_q, err_q;
    logic          busy_nx, ready_nx, err_nx;
    logic [N-1:0]  rdata_q;

    logic          fire;
    logic [AW-1:0] f_idx;
    logic [N-1:0]  f_data;
    logic          f_wr;
    logic          f_bad;
    logic          req_bad;
    logic          unused_bits;

    logic [N-1:0]  mem [DEPTH];

`ifdef MEM_ERR_CHECK_EN
    localparam logic [N:0] LIMIT = (N+1)'(4 * DEPTH);
    assign req_bad = (bus.addr[1:0] != 2'b00) ||
                     ({1'b0, bus.addr} >= LIMIT);
`else
    assign req_bad = 1'b0;
`endif

    assign unused_bits = ^{bus.addr[1:0], bus.addr[N-1:AW+2]};

    // fire marks the edge entering RESP; the f_* fields come from the
    // latches, or straight from the bus when there are no wait states.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        wbuf_nx  = wbuf;
        op_wr_nx = op_wr;
        bad_nx   = bad;
        busy_nx  = busy_q;
        ready_nx = 1'b0;
        err_nx   = 1'b0;
        fire     = 1'b0;
        f_idx    = idx;
        f_data   = wbuf;
        f_wr     = op_wr;
        f_bad    = bad;
        unique case (state)
            IDLE: begin
                if (bus.MemWrite || bus.MemRead) begin
                    idx_nx   = bus.addr[AW+1:2];
                    wbuf_nx  = bus.wdata;
                    op_wr_nx = bus.MemWrite;
                    bad_nx   = req_bad;
                    cnt_nx   = 4'(WAIT_CYCLES);
                    busy_nx  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        fire     = 1'b1;
                        f_idx    = bus.addr[AW+1:2];
                        f_data   = bus.wdata;
                        f_wr     = bus.MemWrite;
                        f_bad    = req_bad;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.MemRead && !bus.MemWrite) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    cnt_nx   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nx = RESP;
                    fire     = 1'b1;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
        if (fire) begin
            ready_nx = 1'b1;
            err_nx   = f_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx     <= '0;
            wbuf    <= '0;
            op_wr   <= 1'b0;
            bad     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            wbuf    <= wbuf_nx;
            op_wr   <= op_wr_nx;
            bad     <= bad_nx;
            ready_q <= ready_nx;
            busy_q  <= busy_nx;
            err_q   <= err_nx;
            if (fire && !f_wr) begin
                rdata_q <= f_bad ? '0 : mem[f_idx];
            end
        end
    end

    // Array has no reset; a write only lands on a clean, non-reset fire.
    always_ff @(posedge clk) begin
        if (!rst && fire && f_wr && !f_bad) begin
            mem[f_idx] <= f_data;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
